// File: rtl/normalize_float64.sv
// normalize_float64: finds the leading-zero count of an unnormalized float64
// significand and left-justifies it so that the leading one sits in bit 62.
// The exponent is adjusted to match. The outputs feed the round-and-pack
// stage's zSign/zExp/zSig inputs through the ap_start/ap_done handshake.
//
// Optional build macro NORMALIZE_FAST_LZC_EN replaces the 6-step iterative
// leading-zero search with a single-cycle combinational counter in FIN.
// This gives a latency of 1 instead of 7, and the results are bit-identical.
module normalize_float64 (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  input  logic               zSign,
  input  logic signed [11:0] zExp,
  input  logic        [63:0] zSig,
  output logic               zSign_o,
  output logic signed [11:0] zExp_o,
  output logic        [63:0] zSig_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_LZC  = 3'b010,
    S_FIN  = 3'b100
  } state_t;

  state_t state;

  // Captured job and working significand
  logic               sgn_r;
  logic signed [11:0] exp_r;
  logic        [63:0] work_r;
  logic               zero_r;

  // Result of the current job, valid while in FIN
  logic        [6:0]  c_cnt;
  logic        [63:0] norm_sig;
  logic        [63:0] res_sig;
  logic signed [11:0] res_exp;

  // Last delivered result, presented outside FIN
  logic               hold_sign;
  logic signed [11:0] hold_exp;
  logic        [63:0] hold_sig;

  // Drop one position to the right, folding the lost bit into bit 0 so
  // that the round stage still sees it as sticky.
  function automatic logic [63:0] jam_shr1(input logic [63:0] v);
    return {1'b0, v[63:2], v[1] | v[0]};
  endfunction

`ifdef NORMALIZE_FAST_LZC_EN
  // Priority search from the MSB; an all-zero input yields 64.
  function automatic logic [6:0] lzc64(input logic [63:0] v);
    logic [6:0] n;
    logic       found;
    n     = 7'd64;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 7'(63 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction
`else
  logic [6:0] clz_r;
  logic [2:0] step_r;
  logic [6:0] lzc_w;
  logic       top_zero;

  // Binary-search window for this step: 32, 16, 8, 4, 2, 1 bits.
  assign lzc_w    = 7'd32 >> step_r;
  assign top_zero = (work_r >> (7'd64 - lzc_w)) == 64'd0;
`endif

  // Control FSM: accept in IDLE, search, present the result for one cycle in FIN
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
`ifdef NORMALIZE_FAST_LZC_EN
            state  <= S_FIN;
`else
            state  <= S_LZC;
            step_r <= 3'd0;
`endif
          end
        end
`ifndef NORMALIZE_FAST_LZC_EN
        S_LZC: begin
          step_r <= step_r + 3'd1;
          if (step_r == 3'd5) state <= S_FIN;
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: capture the job on accept, then shift out leading zero windows
  always_ff @(posedge ap_clk) begin
    if (state == S_IDLE && ap_start) begin
      sgn_r  <= zSign;
      exp_r  <= zExp;
      work_r <= zSig;
      zero_r <= (zSig == 64'd0);
`ifndef NORMALIZE_FAST_LZC_EN
      clz_r  <= 7'd0;
    end else if (state == S_LZC && top_zero) begin
      work_r <= work_r << lzc_w;
      clz_r  <= clz_r + lzc_w;
`endif
    end
  end

  // Result formation: the leading one sits in bit 63 of norm_sig, and one
  // jammed right shift places it in bit 62 (exponent gains the +1).
  always_comb begin
`ifdef NORMALIZE_FAST_LZC_EN
    c_cnt    = zero_r ? 7'd64 : lzc64(work_r);
    norm_sig = work_r << c_cnt;
`else
    // The search tops out at 63 on a zero significand, so zero is tracked apart.
    c_cnt    = zero_r ? 7'd64 : clz_r;
    norm_sig = work_r;
`endif
    res_sig = jam_shr1(norm_sig);
    res_exp = exp_r - $signed({5'd0, c_cnt}) + 12'sd1;
  end

  // Holding registers keep the last result visible between jobs
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      hold_sign <= 1'b0;
      hold_exp  <= 12'sd0;
      hold_sig  <= 64'd0;
    end else if (state == S_FIN) begin
      hold_sign <= sgn_r;
      hold_exp  <= res_exp;
      hold_sig  <= res_sig;
    end
  end

  assign ap_done  = (state == S_FIN);
  assign ap_ready = (state == S_FIN);
  assign ap_idle  = (state == S_IDLE) && !ap_start;

  assign zSign_o  = (state == S_FIN) ? sgn_r   : hold_sign;
  assign zExp_o   = (state == S_FIN) ? res_exp : hold_exp;
  assign zSig_o   = (state == S_FIN) ? res_sig : hold_sig;

endmodule
